raw10_depacker_2lane: RTL and testbench
=======================================

// Module: raw10_depacker_2lane
// PURPOSE
//  Receive-side counterpart of the RAW10 pattern generator: takes the 2-lane (16-bit/cycle) CSI-2
//  RAW10 packed byte stream and rebuilds groups of four 10-bit pixels. Sits after lane merge/
//  packet-header strip in the RX path and feeds the pixel checker / frame buffer writer.
//  Tracks line position, flags misaligned line starts, and applies backpressure.
// PARAMETERS
//  PIXELS_PER_LINE  2592  pixels per line; multiple of 8 (line = PIXELS_PER_LINE*5/4 bytes, here 3240)
//  WIDTH_N_PIXELS   13    width of pixel index counters
//  BPP              10    bits per pixel; only 10 is supported
// PORTS
//  clk            in   1    single clock
//  rst            in   1    asynchronous, active-high reset
//  in_data        in   16   two packed bytes; [7:0] earlier byte, [15:8] later byte
//  in_valid       in   1    in_data valid
//  in_sol         in   1    qualifies first word of a line (sampled with in_valid)
//  in_ready       out  1    accepts in_data when in_valid & in_ready
//  out_pix        out  40   pixel k at [10k+9:10k], k=0..3, pixel 0 earliest
//  out_valid      out  1    out_pix group valid
//  out_ready      in   1    group consumed when out_valid & out_ready
//  out_pix_index  out  13   index of pixel 0 of current group within line (multiple of 4)
//  out_eol        out  1    current group holds last pixel of line
//  sync_err       out  1    one-cycle pulse on framing error
// BEHAVIOUR
//  - Reset: out_valid=0, out_pix=0, out_pix_index=0, out_eol=0, sync_err=0, phase=PH0, in_ready=1.
//  - Byte phase FSM, advances once per accepted word (10 bytes = 2 groups per 5 words):
//    PH0 b0,b1 of A -> PH1 b2,b3 of A -> PH2 b4 of A (group A done) + b0 of B
//    -> PH3 b1,b2 of B -> PH4 b3,b4 of B (group B done) -> PH0.
//  - Unpack: pix k = {b4[2k+1:2k], bk}; low byte bk, MSBs from 5th byte.
//  - Output register: group loaded on the clock edge accepting its completing word; latency 1
//    cycle from completing word to out_valid. Holds stable while out_valid & !out_ready.
//  - in_ready = !(phase in {PH2,PH4} & out_valid & !out_ready); non-completing phases never stall.
//    Simultaneous drain and load in same cycle allowed (no bubble).
//  - in_sol accepted: phase forced to treat word as PH0; pixel counter reset to 0. If prior phase
//    != PH0, partial group discarded and sync_err pulses.
//  - out_pix_index increments by 4 per loaded group; out_eol=1 when index == PIXELS_PER_LINE-4.
//  - After eol group, words until next in_sol are accepted and dropped (no output); first such
//    word pulses sync_err once. Counter saturates, never wraps.
//  - Reset mid-line: all state cleared; stream resynchronises only on next in_sol.
//  - in_valid=0 cycles: state frozen, no effect on phase.
// CONFIGURATION
//  RAW10_DEPACK_STATS_EN defined: adds outputs stat_groups[31:0] (groups loaded, wraps 2^32) and
//  stat_errs[15:0] (sync_err pulses, saturating); both cleared by rst.
//  Not defined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  - Package csi2_raw10_pkg: raw10_phase_t enum (PH0..PH4), BYTES_PER_GROUP=5,
//    PIX_PER_GROUP=4, RAW10 group struct (4 x 10-bit).
//  - Sub-module raw10_group_unpack: combinational 5 bytes -> 4 pixels; shared with TX-side checker.
//  - Top holds phase FSM, 4-byte staging register, output register, line counter, error logic.
// TESTING
//  1 Sol + words 16'h2211,16'h4433,16'h66E4 -> out_pix pix0..3 = 0x011,0x122,0x233,0x344,
//    out_pix_index=0, out_valid 1 cycle after third word.
//  2 Full line of 3240 bytes from generator model, out_ready=1 -> 648 groups, out_eol only on
//    index 2588, no sync_err, in_ready constantly 1.
//  3 out_ready=0 for 10 cycles during streaming -> in_ready drops only in PH2/PH4 with group held;
//    no data loss/duplication vs model after release.
//  4 in_sol after 3 words (phase PH3) -> sync_err 1 pulse, partial group dropped, new line
//    decodes from index 0 correctly.
//  5 Extra 4 words after eol -> dropped, single sync_err pulse, next sol decodes normally.
//  6 rst asserted at PH2 with out_valid=1 -> outputs to reset values immediately (async);
//    words before next in_sol produce nothing.

Source files
------------

// File: rtl/csi2_raw10_pkg.sv
// Shared RAW10 definitions for the CSI-2 RX depacker and the TX-side checker:
// byte-phase and line-state encodings, group geometry and the 4-pixel group layout.
package csi2_raw10_pkg;

  localparam int BYTES_PER_GROUP = 5;
  localparam int PIX_PER_GROUP   = 4;

  // Position of the next accepted 16-bit word inside a 10-byte (2-group) cycle.
  typedef enum logic [2:0] {PH0, PH1, PH2, PH3, PH4} raw10_phase_t;

  // IDLE: waiting for a start of line after reset.
  // DONE: last group of the line emitted, nothing extra seen yet.
  // DROP: surplus words already reported, discarding until the next start of line.
  typedef enum logic [1:0] {LINE_IDLE, LINE_ACTIVE, LINE_DONE, LINE_DROP} line_state_t;

  // Packed so that pixel 0 lands in bits [9:0], matching the out_pix layout.
  typedef struct packed {
    logic [9:0] pix3;
    logic [9:0] pix2;
    logic [9:0] pix1;
    logic [9:0] pix0;
  } raw10_group_t;

  function automatic raw10_phase_t next_phase(input raw10_phase_t ph);
    case (ph)
      PH0:     return PH1;
      PH1:     return PH2;
      PH2:     return PH3;
      PH3:     return PH4;
      default: return PH0;
    endcase
  endfunction

endpackage

// File: rtl/raw10_group_unpack.sv
// Combinational RAW10 group unpacker: five packed bytes in, four 10-bit pixels out.
// Byte k (k=0..3) carries the low 8 bits of pixel k; byte 4 carries the two MSBs of
// every pixel, pixel k at bits [2k+1:2k].
module raw10_group_unpack
  import csi2_raw10_pkg::*;
(
  input  logic [8*BYTES_PER_GROUP-1:0] group_bytes,
  output raw10_group_t                 pix
);

  logic [7:0] msb_byte;

  assign msb_byte = group_bytes[39:32];

  assign pix.pix0 = {msb_byte[1:0], group_bytes[7:0]};
  assign pix.pix1 = {msb_byte[3:2], group_bytes[15:8]};
  assign pix.pix2 = {msb_byte[5:4], group_bytes[23:16]};
  assign pix.pix3 = {msb_byte[7:6], group_bytes[31:24]};

endmodule

// File: rtl/raw10_depacker_2lane.sv
// 2-lane (16 bit/cycle) CSI-2 RAW10 depacker: rebuilds 4-pixel groups from the packed
// byte stream, tracks the pixel position within the line, reports framing errors and
// stalls the input only when a completing word would overwrite a group not yet taken.
// Optional build macro RAW10_DEPACK_STATS_EN adds group and error statistics outputs.
module raw10_depacker_2lane
  import csi2_raw10_pkg::*;
#(
  parameter int PIXELS_PER_LINE = 2592,
  parameter int WIDTH_N_PIXELS  = 13,
  parameter int BPP             = 10
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [15:0]                      in_data,
  input  logic                             in_valid,
  input  logic                             in_sol,
  output logic                             in_ready,
  output logic [PIX_PER_GROUP*BPP-1:0]     out_pix,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [WIDTH_N_PIXELS-1:0]        out_pix_index,
  output logic                             out_eol,
  output logic                             sync_err
`ifdef RAW10_DEPACK_STATS_EN
  ,
  output logic [31:0]                      stat_groups,
  output logic [15:0]                      stat_errs
`endif
);

  localparam logic [WIDTH_N_PIXELS-1:0] LAST_INDEX =
    WIDTH_N_PIXELS'(PIXELS_PER_LINE - PIX_PER_GROUP);
  localparam logic [WIDTH_N_PIXELS-1:0] INDEX_STEP = WIDTH_N_PIXELS'(PIX_PER_GROUP);

  raw10_phase_t                phase;
  raw10_phase_t                eff_phase;
  line_state_t                 line_state;
  logic [7:0]                  stage [4];
  logic [WIDTH_N_PIXELS-1:0]   pix_cnt;
  logic [8*BYTES_PER_GROUP-1:0] group_bytes;
  raw10_group_t                unpacked;
  logic                        accept;
  logic                        start_line;
  logic                        active;
  logic                        load;
  logic                        misalign_err;
  logic                        overrun_err;

  // Only the group-completing phases can collide with a group still waiting downstream.
  assign in_ready     = !(((phase == PH2) || (phase == PH4)) && out_valid && !out_ready);
  assign accept       = in_valid && in_ready;
  assign start_line   = accept && in_sol;
  assign eff_phase    = start_line ? PH0 : phase;
  assign active       = start_line || (line_state == LINE_ACTIVE);
  assign load         = accept && active && ((eff_phase == PH2) || (eff_phase == PH4));
  assign misalign_err = start_line && (line_state == LINE_ACTIVE) && (phase != PH0);
  assign overrun_err  = accept && !in_sol && (line_state == LINE_DONE);

  // Assemble the five bytes of the group completed by the current word.
  // NOTE: every always_comb output gets a full default first so no latch is inferred.
  always_comb begin
    group_bytes = {in_data[7:0], stage[3], stage[2], stage[1], stage[0]};
    if (phase != PH2) begin
      group_bytes = {in_data[15:8], in_data[7:0], stage[2], stage[1], stage[0]};
    end
  end

  raw10_group_unpack u_unpack (
    .group_bytes (group_bytes),
    .pix         (unpacked)
  );

  // Stage the bytes of a partially received group.
  // NOTE: staging bytes are pure datapath qualified by the phase FSM, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept && active) begin
      case (eff_phase)
        PH0: begin
          stage[0] <= in_data[7:0];
          stage[1] <= in_data[15:8];
        end
        PH1: begin
          stage[2] <= in_data[7:0];
          stage[3] <= in_data[15:8];
        end
        PH2: stage[0] <= in_data[15:8];
        PH3: begin
          stage[1] <= in_data[7:0];
          stage[2] <= in_data[15:8];
        end
        default: ;
      endcase
    end
  end

  // Byte-phase FSM and line position tracking.
  // NOTE: sequential state uses nonblocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase      <= PH0;
      line_state <= LINE_IDLE;
      pix_cnt    <= '0;
    end else if (accept) begin
      if (active) begin
        phase <= next_phase(eff_phase);
        if (start_line) begin
          line_state <= LINE_ACTIVE;
          pix_cnt    <= '0;
        end else if (load) begin
          if (pix_cnt == LAST_INDEX) begin
            line_state <= LINE_DONE;
          end else begin
            pix_cnt <= pix_cnt + INDEX_STEP;
          end
        end
      end else if (line_state == LINE_DONE) begin
        line_state <= LINE_DROP;
      end
    end
  end

  // Output group register and framing-error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_pix       <= '0;
      out_valid     <= 1'b0;
      out_pix_index <= '0;
      out_eol       <= 1'b0;
      sync_err      <= 1'b0;
    end else begin
      sync_err <= misalign_err || overrun_err;
      if (load) begin
        out_pix       <= unpacked;
        out_valid     <= 1'b1;
        out_pix_index <= pix_cnt;
        out_eol       <= (pix_cnt == LAST_INDEX);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef RAW10_DEPACK_STATS_EN
  // Loaded-group count wraps; error count saturates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_groups <= '0;
      stat_errs   <= '0;
    end else begin
      if (load) begin
        stat_groups <= stat_groups + 32'd1;
      end
      if ((misalign_err || overrun_err) && (stat_errs != 16'hFFFF)) begin
        stat_errs <= stat_errs + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_raw10_depacker_2lane.sv
// Directed bench for raw10_depacker_2lane: a byte-level RAW10 packer model pushes
// expected groups into a scoreboard queue as words are driven; a monitor pops and
// compares each group as the DUT hands it downstream.
module tb_raw10_depacker_2lane;

  localparam int PPL    = 2592;
  localparam int GROUPS = PPL / 4;

  typedef struct packed {
    logic [39:0] pix;
    logic [12:0] idx;
    logic        eol;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_sol = 1'b0;
  logic        in_ready;
  logic [39:0] out_pix;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [12:0] out_pix_index;
  logic        out_eol;
  logic        sync_err;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   stall_lo = 0;
  int   stall_hi = 0;
  bit   stall_req = 1'b0;
  int   groups_seen = 0;
  int   eol_seen = 0;
  int   err_seen = 0;
  int   ready_low = 0;
  int   cur_phase = 0;

  raw10_depacker_2lane dut (
    .clk           (clk),
    .rst           (rst),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_sol        (in_sol),
    .in_ready      (in_ready),
    .out_pix       (out_pix),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pix_index (out_pix_index),
    .out_eol       (out_eol),
    .sync_err      (sync_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] pix_val(input int seed, input int i);
    return 10'((i * 37 + seed * 101 + (i >> 2) * 5) ^ (seed << 3));
  endfunction

  // Downstream side: out_ready schedule, then scoreboard and stall-rule checks mid-cycle.
  always @(negedge clk) begin
    cyc++;
    out_ready = !(stall_req || (cyc >= stall_lo && cyc < stall_hi));
    #1;
    if (!rst) begin
      if (sync_err) err_seen++;
      if (in_valid && !in_ready) begin
        ready_low++;
        check("stall_phase", 64'(cur_phase == 2 || cur_phase == 4), 64'd1);
        check("stall_cause", 64'(out_valid && !out_ready), 64'd1);
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_group", 64'(out_pix), 64'hDEAD_0000_0000);
        end else begin
          check("out_pix", 64'(out_pix), 64'(exp_q[0].pix));
          check("out_pix_index", 64'(out_pix_index), 64'(exp_q[0].idx));
          check("out_eol", 64'(out_eol), 64'(exp_q[0].eol));
          if (out_ready) begin
            groups_seen++;
            if (out_eol) eol_seen++;
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  // Drive one word; returns just after the negedge following the accepting posedge.
  task automatic send_word(input logic [15:0] d, input logic s, input int ph);
    bit acc;
    int guard = 0;
    cur_phase = ph;
    in_data   = d;
    in_sol    = s;
    in_valid  = 1'b1;
    forever begin
      #1;
      acc = in_ready;
      @(negedge clk);
      if (acc) break;
      guard++;
      if (guard > 200) begin
        check("in_ready_timeout", 64'd0, 64'd1);
        break;
      end
    end
    in_valid = 1'b0;
    in_sol   = 1'b0;
  endtask

  // Pack n_groups groups of model pixels into bytes and stream them as 16-bit words.
  // The expected group is queued when the word carrying its fifth byte is driven.
  task automatic send_line(input int seed, input int n_groups, input bit with_sol,
                           input bit expect_out, input int stall_at_word);
    logic [7:0] bytes[$];
    exp_t       grp[$];
    logic [9:0] p[4];
    exp_t       e;
    for (int g = 0; g < n_groups; g++) begin
      for (int k = 0; k < 4; k++) begin
        p[k] = pix_val(seed, 4 * g + k);
        bytes.push_back(p[k][7:0]);
      end
      bytes.push_back({p[3][9:8], p[2][9:8], p[1][9:8], p[0][9:8]});
      e.pix = {p[3], p[2], p[1], p[0]};
      e.idx = 13'(4 * g);
      e.eol = (4 * g == PPL - 4);
      grp.push_back(e);
    end
    for (int w = 0; w < bytes.size() / 2; w++) begin
      for (int b = 2 * w; b <= 2 * w + 1; b++) begin
        if (expect_out && b >= 4 && (b - 4) % 5 == 0) exp_q.push_back(grp[(b - 4) / 5]);
      end
      if (w == stall_at_word) stall_req = 1'b1;
      send_word({bytes[2 * w + 1], bytes[2 * w]}, with_sol && (w == 0), w % 5);
    end
  endtask

  task automatic wait_drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    repeat (2) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    exp_t e;
    int   e0, g0, r0, l0;

    // Reset state
    #1 rst = 1'b1;
    #2;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_pix", 64'(out_pix), 64'd0);
    check("rst_out_pix_index", 64'(out_pix_index), 64'd0);
    check("rst_out_eol", 64'(out_eol), 64'd0);
    check("rst_sync_err", 64'(sync_err), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);

    // Known-answer group
    e.pix = {10'h344, 10'h233, 10'h122, 10'h011};
    e.idx = '0;
    e.eol = 1'b0;
    send_word(16'h2211, 1'b1, 0);
    #1 check("kat_no_early_valid1", 64'(out_valid), 64'd0);
    send_word(16'h4433, 1'b0, 1);
    #1 check("kat_no_early_valid2", 64'(out_valid), 64'd0);
    exp_q.push_back(e);
    send_word(16'h66E4, 1'b0, 2);
    #1 check("kat_valid_latency", 64'(out_valid), 64'd1);
    wait_drain();

    // Start of line while in PH3: partial group dropped, one error pulse, clean restart
    e0 = err_seen; g0 = groups_seen;
    send_line(1, 4, 1'b1, 1'b1, -1);
    wait_drain();
    check("misalign_err_pulses", 64'(err_seen - e0), 64'd1);
    check("misalign_groups", 64'(groups_seen - g0), 64'd4);

    // Full line, free-running sink
    e0 = err_seen; g0 = groups_seen; r0 = ready_low; l0 = eol_seen;
    send_line(2, GROUPS, 1'b1, 1'b1, -1);
    wait_drain();
    check("line_groups", 64'(groups_seen - g0), 64'(GROUPS));
    check("line_eol_count", 64'(eol_seen - l0), 64'd1);
    check("line_no_err", 64'(err_seen - e0), 64'd0);
    check("line_ready_high", 64'(ready_low - r0), 64'd0);

    // Surplus words after end of line
    e0 = err_seen; g0 = groups_seen;
    send_word(16'hA1A0, 1'b0, 0);
    send_word(16'hA3A2, 1'b0, 1);
    send_word(16'hA5A4, 1'b0, 2);
    send_word(16'hA7A6, 1'b0, 3);
    repeat (3) @(negedge clk);
    check("overrun_err_pulses", 64'(err_seen - e0), 64'd1);
    check("overrun_no_groups", 64'(groups_seen - g0), 64'd0);

    // Full line with a 10-cycle sink stall in the middle
    e0 = err_seen; g0 = groups_seen; r0 = ready_low;
    stall_lo = cyc + 40;
    stall_hi = stall_lo + 10;
    send_line(3, GROUPS, 1'b1, 1'b1, -1);
    wait_drain();
    check("stall_line_groups", 64'(groups_seen - g0), 64'(GROUPS));
    check("stall_line_no_err", 64'(err_seen - e0), 64'd0);
    check("stall_seen", 64'(ready_low > r0), 64'd1);

    // Async reset while in PH2 with a group held
    send_line(4, 2, 1'b1, 1'b1, 4);
    send_word(16'h5150, 1'b0, 0);
    send_word(16'h5352, 1'b0, 1);
    #1 check("pre_rst_valid", 64'(out_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_out_valid", 64'(out_valid), 64'd0);
    check("async_rst_out_pix", 64'(out_pix), 64'd0);
    check("async_rst_out_pix_index", 64'(out_pix_index), 64'd0);
    check("async_rst_in_ready", 64'(in_ready), 64'd1);
    exp_q.delete();
    stall_req = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);

    e0 = err_seen; g0 = groups_seen;
    for (int w = 0; w < 5; w++) send_word(16'(16'h7170 + 16'h0202 * w), 1'b0, w);
    repeat (3) @(negedge clk);
    check("post_rst_no_groups", 64'(groups_seen - g0), 64'd0);
    check("post_rst_no_err", 64'(err_seen - e0), 64'd0);

    g0 = groups_seen;
    send_line(5, 4, 1'b1, 1'b1, -1);
    wait_drain();
    check("resync_groups", 64'(groups_seen - g0), 64'd4);
    check("resync_no_err", 64'(err_seen - e0), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
